// File: rtl/apb_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : apb_timer_pkg
// Brief    : Shared register offsets, CTRL bit positions and FSM encodings
// Revision : 1.0 - initial release
// ============================================================================
package apb_timer_pkg;

    localparam logic [4:0] OFF_CTRL     = 5'h00;
    localparam logic [4:0] OFF_STATUS   = 5'h04;
    localparam logic [4:0] OFF_COUNT    = 5'h08;
    localparam logic [4:0] OFF_COMPARE  = 5'h0C;
    localparam logic [4:0] OFF_PRESCALE = 5'h10;

    localparam int CTRL_EN = 0;
    localparam int CTRL_IE = 1;
    localparam int CTRL_AR = 2;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

endpackage
`default_nettype wire

// File: rtl/timer_counter.sv
`default_nettype none
// ============================================================================
// Module   : timer_counter
// Brief    : Prescaler, COUNT register and compare/pend logic of the timer
// Revision : 1.0 - initial release
// ============================================================================
module timer_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_en,
    input  logic        i_autoreload,
    input  logic [31:0] i_compare,
    input  logic [15:0] i_prescale,
    input  logic        i_presc_clr,
    input  logic [3:0]  i_count_we,
    input  logic [31:0] i_wdata,
    input  logic        i_pend_clr,
    output logic [31:0] o_count,
    output logic        o_pend
);

    logic [15:0] r_presc_cnt;
    logic [31:0] r_count;
    logic        r_pend;
    logic        w_tick;
    logic        w_hit;
    logic [31:0] w_count_ticked;
    logic [31:0] w_count_next;

    assign w_tick = i_en && (r_presc_cnt == i_prescale);
    assign w_hit  = w_tick && (r_count == i_compare);

    always_comb begin
        w_count_ticked = r_count;
        if (w_tick) begin
            w_count_ticked = (w_hit && i_autoreload) ? 32'd0 : r_count + 32'd1;
        end
    end

    // Software writes win per byte lane; untouched lanes keep the ticked value
    for (genvar g = 0; g < 4; g++) begin : g_lane
        assign w_count_next[8*g +: 8] = i_count_we[g] ? i_wdata[8*g +: 8]
                                                      : w_count_ticked[8*g +: 8];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc_cnt <= 16'd0;
            r_count     <= 32'd0;
            r_pend      <= 1'b0;
        end else begin
            if (i_presc_clr) begin
                r_presc_cnt <= 16'd0;
            end else if (i_en) begin
                r_presc_cnt <= w_tick ? 16'd0 : r_presc_cnt + 16'd1;
            end
            r_count <= w_count_next;
            if (w_hit) begin
                r_pend <= 1'b1;
            end else if (i_pend_clr) begin
                r_pend <= 1'b0;
            end
        end
    end

    assign o_count = r_count;
    assign o_pend  = r_pend;

endmodule
`default_nettype wire

// File: rtl/apb_timer.sv
`default_nettype none
// ============================================================================
// Module   : apb_timer
// Brief    : APB completer with wait states, register decode and timer IRQ
// Revision : 1.0 - initial release
// ============================================================================
module apb_timer
    import apb_timer_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_STATES = 1
) (
    input  logic                  clk,
    input  logic                  rts,
    input  logic [ADDR_WIDTH-1:0] APB_paddr,
    input  logic [DATA_WIDTH-1:0] APB_pdata,
    output logic [DATA_WIDTH-1:0] APB_prdata,
    input  logic                  APB_psel,
    input  logic                  APB_penable,
    input  logic                  APB_pwrite,
    input  logic [3:0]            APB_pstb,
    output logic                  APB_pready,
    output logic                  APB_perr,
    output logic                  interrupt
);

    localparam logic [2:0] c_wait_load = 3'(WAIT_STATES);

    logic [1:0]  r_state;
    logic [2:0]  r_wait;
    logic [2:0]  r_ctrl;
    logic [31:0] r_compare;
    logic [15:0] r_prescale;
    logic        r_irq;

    logic [4:0]  w_off;
    logic        w_err;
    logic        w_done;
    logic        w_wr;
    logic        w_unused_addr;
    logic [31:0] w_rdata;
    logic [31:0] w_count;
    logic        w_pend;
    logic [3:0]  w_count_we;
    logic        w_presc_clr;
    logic        w_pend_clr;

    assign w_off         = APB_paddr[4:0];
    assign w_unused_addr = ^APB_paddr[ADDR_WIDTH-1:5];
    assign w_err         = (w_off[1:0] != 2'b00) || (w_off > OFF_PRESCALE);
    assign w_done        = (r_state == DONE);
    assign w_wr          = w_done && APB_psel && APB_pwrite && !w_err;
    assign w_count_we    = (w_wr && (w_off == OFF_COUNT)) ? APB_pstb : 4'b0000;
    assign w_presc_clr   = w_wr && (w_off == OFF_PRESCALE);
    assign w_pend_clr    = w_wr && (w_off == OFF_STATUS) && APB_pstb[0] && APB_pdata[0];

    // The counter reaches zero on the edge that enters DONE, so DONE lands in
    // access cycle WAIT_STATES+1; with no wait states setup goes straight to DONE.
    always_ff @(posedge clk) begin
        if (rts) begin
            r_state <= IDLE;
            r_wait  <= 3'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (APB_psel && !APB_penable) begin
                        r_wait  <= c_wait_load;
                        r_state <= (c_wait_load == 3'd0) ? DONE : ACCESS;
                    end
                end
                ACCESS: begin
                    if (!APB_psel) begin
                        r_state <= IDLE;
                    end else if (APB_penable) begin
                        r_wait <= r_wait - 3'd1;
                        if (r_wait == 3'd1) begin
                            r_state <= DONE;
                        end
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rts) begin
            r_ctrl     <= 3'd0;
            r_compare  <= 32'd0;
            r_prescale <= 16'd0;
            r_irq      <= 1'b0;
        end else begin
            r_irq <= w_pend && r_ctrl[CTRL_IE];
            if (w_wr && (w_off == OFF_CTRL) && APB_pstb[0]) begin
                r_ctrl <= APB_pdata[2:0];
            end
            for (int i = 0; i < 4; i++) begin
                if (w_wr && (w_off == OFF_COMPARE) && APB_pstb[i]) begin
                    r_compare[8*i +: 8] <= APB_pdata[8*i +: 8];
                end
            end
            for (int i = 0; i < 2; i++) begin
                if (w_wr && (w_off == OFF_PRESCALE) && APB_pstb[i]) begin
                    r_prescale[8*i +: 8] <= APB_pdata[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        w_rdata = 32'd0;
        case (w_off)
            OFF_CTRL:     w_rdata = {29'd0, r_ctrl};
            OFF_STATUS:   w_rdata = {31'd0, w_pend};
            OFF_COUNT:    w_rdata = w_count;
            OFF_COMPARE:  w_rdata = r_compare;
            OFF_PRESCALE: w_rdata = {16'd0, r_prescale};
            default:      w_rdata = 32'd0;
        endcase
    end

    timer_counter u_timer (
        .clk          (clk),
        .rst          (rts),
        .i_en         (r_ctrl[CTRL_EN]),
        .i_autoreload (r_ctrl[CTRL_AR]),
        .i_compare    (r_compare),
        .i_prescale   (r_prescale),
        .i_presc_clr  (w_presc_clr),
        .i_count_we   (w_count_we),
        .i_wdata      (APB_pdata),
        .i_pend_clr   (w_pend_clr),
        .o_count      (w_count),
        .o_pend       (w_pend)
    );

    assign APB_pready = w_done;
    assign APB_perr   = w_done && w_err;
    assign APB_prdata = (w_done && !APB_pwrite && !w_err) ? w_rdata : '0;
    assign interrupt  = r_irq;

endmodule
`default_nettype wire
